// File: rtl/r_resp_buffer.sv
// Per-slave R-channel response buffer: DEPTH-entry circular FIFO of {RID, RDATA, RRESP, RLAST}.
// Define RBUF_BURST_GATE_EN to offer a burst only once its RLAST beat is stored (or the buffer is full).
module r_resp_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned IDS_W  = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDS_W-1:0]  S_RID,
  input  logic [DATA_W-1:0] S_RDATA,
  input  logic [1:0]        S_RRESP,
  input  logic              S_RLAST,
  input  logic              S_RVALID,
  output logic              S_RREADY,
  output logic [IDS_W-1:0]  RID_S,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = IDS_W + DATA_W + 3;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] bursts;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic          burst_inc;
  logic          burst_dec;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // Ready depends only on registered occupancy, so RREADY never reaches S_RREADY.
  assign S_RREADY = ~rst & ~full;

`ifdef RBUF_BURST_GATE_EN
  assign RVALID = ~rst & ~empty & ((bursts != '0) | full);
`else
  assign RVALID = ~rst & ~empty;
`endif

  assign {RID_S, RDATA, RRESP, RLAST} = (~rst & ~empty) ? head : '0;

  assign push      = S_RVALID & S_RREADY;
  assign pop       = RVALID & RREADY;
  assign burst_inc = push & S_RLAST;
  assign burst_dec = pop & head[0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {S_RID, S_RDATA, S_RRESP, S_RLAST};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      bursts <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({burst_inc, burst_dec})
        2'b10:   bursts <= bursts + CW'(1);
        2'b01:   bursts <= bursts - CW'(1);
        default: bursts <= bursts;
      endcase
    end
  end

endmodule

// File: tb/tb_r_resp_buffer.sv
// Directed bench for r_resp_buffer (DEPTH=4); gating-specific steps follow RBUF_BURST_GATE_EN.
module tb_r_resp_buffer;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned IDS_W  = 8;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [IDS_W-1:0]  S_RID = '0;
  logic [DATA_W-1:0] S_RDATA = '0;
  logic [1:0]        S_RRESP = '0;
  logic              S_RLAST = 1'b0;
  logic              S_RVALID = 1'b0;
  logic              S_RREADY;
  logic [IDS_W-1:0]  RID_S;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY = 1'b0;

  int passed = 0;
  int total  = 0;

  logic [DATA_W-1:0] qd [$];
  logic              ql [$];

  r_resp_buffer #(.DEPTH(DEPTH), .IDS_W(IDS_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .RID_S(RID_S), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference FIFO: checks outputs, then advances one clock with the current inputs.
  task automatic mstep(input string tag, output logic accepted);
    int n;
    int nb;
    logic ev;
    logic do_push;
    logic do_pop;
    logic [DATA_W-1:0] d;
    logic l;
    n  = qd.size();
    nb = 0;
    foreach (ql[i]) if (ql[i]) nb++;
`ifdef RBUF_BURST_GATE_EN
    ev = (n != 0) && ((nb != 0) || (n == DEPTH));
`else
    ev = (n != 0);
`endif
    chk({tag, "_rvalid"}, 64'(RVALID), 64'(ev));
    chk({tag, "_s_rready"}, 64'(S_RREADY), 64'(n != DEPTH));
    if (ev) begin
      chk({tag, "_rdata"}, 64'(RDATA), 64'(qd[0]));
      chk({tag, "_rlast"}, 64'(RLAST), 64'(ql[0]));
    end
    do_push = S_RVALID && (n != DEPTH);
    do_pop  = RREADY && ev;
    d = S_RDATA;
    l = S_RLAST;
    cyc();
    if (do_pop) begin
      void'(qd.pop_front());
      void'(ql.pop_front());
    end
    if (do_push) begin
      qd.push_back(d);
      ql.push_back(l);
    end
    accepted = do_push;
  endtask

  initial begin
    logic acc;
    int b;
    int budget;

    // Reset state
    cyc(); cyc();
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_s_rready", 64'(S_RREADY), 64'd0);
    chk("rst_rdata", 64'(RDATA), 64'd0);
    chk("rst_rid", 64'(RID_S), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_rready", 64'(S_RREADY), 64'd1);

    // Single beat, no fall-through, popped the cycle it appears
    S_RID = 8'h12; S_RDATA = 32'hDEADBEEF; S_RRESP = 2'b00; S_RLAST = 1'b1;
    S_RVALID = 1'b1; RREADY = 1'b1;
    #1;
    chk("single_no_fallthru", 64'(RVALID), 64'd0);
    cyc();
    S_RVALID = 1'b0;
    #1;
    chk("single_rvalid", 64'(RVALID), 64'd1);
    chk("single_rid", 64'(RID_S), 64'h12);
    chk("single_rdata", 64'(RDATA), 64'hDEADBEEF);
    chk("single_rlast", 64'(RLAST), 64'd1);
    chk("single_rresp", 64'(RRESP), 64'd0);
    cyc();
    chk("single_empty_rvalid", 64'(RVALID), 64'd0);
    chk("single_empty_rdata", 64'(RDATA), 64'd0);

    // Fill and stall, then drain; a waiting beat must not push through while full
    RREADY = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      S_RVALID = 1'b1; S_RDATA = 32'(i); S_RID = 8'(8'h30 + i); S_RLAST = (i == 4);
      S_RRESP = 2'(i);
      #1;
      chk("fill_s_rready", 64'(S_RREADY), 64'd1);
      cyc();
    end
    S_RDATA = 32'h99; S_RLAST = 1'b0; RREADY = 1'b1;
    #1;
    chk("full_s_rready", 64'(S_RREADY), 64'd0);
    chk("full_rvalid", 64'(RVALID), 64'd1);
    chk("drain_rdata_1", 64'(RDATA), 64'd1);
    chk("drain_rid_1", 64'(RID_S), 64'h31);
    cyc();
    S_RVALID = 1'b0;
    #1;
    chk("after_pop_s_rready", 64'(S_RREADY), 64'd1);
    chk("drain_rdata_2", 64'(RDATA), 64'd2);
    chk("drain_rresp_2", 64'(RRESP), 64'd2);
    cyc();
    chk("drain_rdata_3", 64'(RDATA), 64'd3);
    chk("drain_rresp_3", 64'(RRESP), 64'd3);
    chk("drain_rlast_3", 64'(RLAST), 64'd0);
    cyc();
    chk("drain_rdata_4", 64'(RDATA), 64'd4);
    chk("drain_rlast_4", 64'(RLAST), 64'd1);
    chk("drain_rvalid_4", 64'(RVALID), 64'd1);
    cyc();
    chk("drain_no_pushthru", 64'(RVALID), 64'd0);

`ifdef RBUF_BURST_GATE_EN
    // Burst gated until its RLAST beat is stored
    RREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      S_RVALID = 1'b1; S_RDATA = 32'(32'h40 + i); S_RLAST = (i == 3);
      #1;
      chk("gate_hold_rvalid", 64'(RVALID), 64'd0);
      cyc();
    end
    S_RVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("gate_drain_rvalid", 64'(RVALID), 64'd1);
      chk("gate_drain_rdata", 64'(RDATA), 64'(32'h40 + i));
      cyc();
    end
    chk("gate_done_rvalid", 64'(RVALID), 64'd0);

    // 8-beat burst streams once the buffer fills
    b = 0; budget = 60;
    while (b < 8 && budget > 0) begin
      S_RVALID = 1'b1; S_RDATA = 32'(32'h80 + b); S_RLAST = (b == 7); RREADY = 1'b1;
      mstep("long", acc);
      if (acc) b++;
      budget--;
    end
    chk("long_all_pushed", 64'(b), 64'd8);
    S_RVALID = 1'b0;
    budget = 20;
    while (qd.size() != 0 && budget > 0) begin
      mstep("long_drain", acc);
      budget--;
    end
    chk("long_drained", 64'(qd.size()), 64'd0);
`else
    // Plain FIFO: RLAST=0 beat is offered one cycle after push
    RREADY = 1'b0;
    S_RVALID = 1'b1; S_RDATA = 32'h55; S_RLAST = 1'b0;
    cyc();
    S_RVALID = 1'b0;
    #1;
    chk("fifo_rvalid", 64'(RVALID), 64'd1);
    chk("fifo_rdata", 64'(RDATA), 64'h55);
    RREADY = 1'b1;
    cyc();
    chk("fifo_empty_rvalid", 64'(RVALID), 64'd0);
`endif

    // Continuous stream with RREADY=1: pointers wrap, count stays at 1
    RREADY = 1'b1;
    for (int k = 0; k < 10; k++) begin
      S_RVALID = 1'b1; S_RDATA = 32'(32'h100 + k); S_RLAST = 1'b1; S_RRESP = 2'(k);
      mstep("stream", acc);
      chk("stream_accept", 64'(acc), 64'd1);
    end
    S_RVALID = 1'b0;
    chk("stream_tail", 64'(RDATA), 64'h109);
    mstep("stream_tail_step", acc);
    chk("stream_done", 64'(RVALID), 64'd0);

    // RREADY toggling with a continuous source
    b = 0;
    for (int k = 0; k < 14; k++) begin
      S_RVALID = 1'b1; S_RDATA = 32'(32'h200 + b); S_RLAST = 1'b1; RREADY = (k % 2 == 1);
      mstep("toggle", acc);
      if (acc) b++;
    end
    S_RVALID = 1'b0; RREADY = 1'b1;
    budget = 10;
    while (qd.size() != 0 && budget > 0) begin
      mstep("toggle_drain", acc);
      budget--;
    end
    chk("toggle_drained", 64'(qd.size()), 64'd0);
    chk("toggle_rvalid_end", 64'(RVALID), 64'd0);

    // Reset mid-burst discards the partial burst
    RREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      S_RVALID = 1'b1; S_RDATA = 32'(32'h300 + i); S_RLAST = 1'b0;
      cyc();
    end
    S_RVALID = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_s_rready", 64'(S_RREADY), 64'd0);
    chk("midrst_rvalid", 64'(RVALID), 64'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("postrst_rvalid", 64'(RVALID), 64'd0);
    chk("postrst_rdata", 64'(RDATA), 64'd0);
    chk("postrst_s_rready", 64'(S_RREADY), 64'd1);
    S_RVALID = 1'b1; S_RID = 8'h21; S_RDATA = 32'hCAFEF00D; S_RRESP = 2'b10; S_RLAST = 1'b1;
    cyc();
    S_RVALID = 1'b0;
    #1;
    chk("new_rvalid", 64'(RVALID), 64'd1);
    chk("new_rid", 64'(RID_S), 64'h21);
    chk("new_rdata", 64'(RDATA), 64'hCAFEF00D);
    chk("new_rresp", 64'(RRESP), 64'd2);
    chk("new_rlast", 64'(RLAST), 64'd1);
    RREADY = 1'b1;
    cyc();
    chk("new_done_rvalid", 64'(RVALID), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
